// File: rtl/alu_arb.sv
// ---------------------------------------------------------------------------
// alu_arb : two-requester round-robin front end for a single shared ALU.
//
// Each cycle at most one requester is granted. Its operands and control go
// combinationally to the external ALU, and the ALU result is captured in a
// one-entry output slot that the consumer drains with resp_ready.
//
// The slot can be drained and refilled in the same cycle. A saturating
// counter per requester counts the operations that were accepted.
// ---------------------------------------------------------------------------
module alu_arb #(
    parameter int DATA_LEN = 32,
    parameter int CNT_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    // requester 0
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_LEN-1:0] req0_a,
    input  logic [DATA_LEN-1:0] req0_b,
    input  logic [8:0]          req0_ctrl,

    // requester 1
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_LEN-1:0] req1_a,
    input  logic [DATA_LEN-1:0] req1_b,
    input  logic [8:0]          req1_ctrl,

    // shared ALU
    output logic [DATA_LEN-1:0] alu_a,
    output logic [DATA_LEN-1:0] alu_b,
    output logic [8:0]          alu_ctrl,
    input  logic [DATA_LEN-1:0] alu_res,
    input  logic [5:0]          alu_flags,

    // response slot
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [DATA_LEN-1:0] resp_res,
    output logic [5:0]          resp_flags,

    // statistics
    output logic [CNT_LEN-1:0]  grant_cnt0,
    output logic [CNT_LEN-1:0]  grant_cnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

    slot_state_e         state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q,         id_d;
    logic [DATA_LEN-1:0] res_q,        res_d;
    logic [5:0]          flags_q,      flags_d;
    logic [CNT_LEN-1:0]  cnt0_q,       cnt0_d;
    logic [CNT_LEN-1:0]  cnt1_q,       cnt1_d;

    logic can_accept;   // slot empty, or draining this cycle
    logic grant_vld;    // a transfer is accepted this cycle
    logic grant_idx;    // index of the requester that wins
    logic out_grant;    // grant as seen on the ports (suppressed in reset)

    // Arbitration: a lone requester wins; on a tie the requester that did not
    // win last time goes first.
    // NOTE: every signal written in an always_comb gets a default value first,
    // so that no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        can_accept = 1'b0;
        grant_idx  = 1'b0;
        grant_vld  = 1'b0;

        can_accept = (state_q == ST_EMPTY) || resp_ready;

        if (req0_valid && req1_valid) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = req1_valid;
        end

        grant_vld = can_accept && (req0_valid || req1_valid);
    end

    // The handshake and the ALU operands are visible on the ports only while
    // out of reset. rst_n gates only these outputs and never the next-state
    // logic: the flops are held in reset anyway.
    assign out_grant = grant_vld && rst_n;

    // Port-facing handshake and operand mux; operands are zero when idle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = '0;

        if (out_grant) begin
            if (grant_idx) begin
                req1_ready = 1'b1;
                alu_a      = req1_a;
                alu_b      = req1_b;
                alu_ctrl   = req1_ctrl;
            end else begin
                req0_ready = 1'b1;
                alu_a      = req0_a;
                alu_b      = req0_b;
                alu_ctrl   = req0_ctrl;
            end
        end
    end

    // Slot FSM: an accepted transfer fills the slot. A drain with no refill
    // empties it. Otherwise the slot keeps its state.
    always_comb begin
        state_d = state_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (grant_vld) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (grant_vld) begin
                    state_d = ST_FULL;
                end else if (resp_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Response payload and round-robin pointer change only on acceptance.
    // A drain leaves the payload in place.
    always_comb begin
        res_d        = res_q;
        flags_d      = flags_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;

        if (grant_vld) begin
            res_d        = alu_res;
            flags_d      = alu_flags;
            id_d         = grant_idx;
            last_grant_d = grant_idx;
        end
    end

    // Per-requester acceptance counters that stop at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;

        if (grant_vld && !grant_idx && (cnt0_q != CNT_MAX)) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (grant_vld && grant_idx && (cnt1_q != CNT_MAX)) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    // State registers. Reset empties the slot, drops any response in flight
    // and sets last_grant to 1, so that requester 0 wins the first tie.
    // NOTE: sequential state uses non-blocking assignments only, so that every
    // flop samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            res_q        <= '0;
            flags_q      <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            res_q        <= res_d;
            flags_q      <= flags_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_id    = id_q;
    assign resp_res   = res_q;
    assign resp_flags = flags_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_arb : self-checking bench for alu_arb.
//
// The bench supplies a behavioural ALU on the alu_* ports. A transaction-level
// reference model predicts, cycle by cycle, the grants, the ALU operands, the
// response slot and the counters. Directed scenarios come first, then a
// randomised run.
// ---------------------------------------------------------------------------
module tb_alu_arb;

    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [8:0]    req0_ctrl, req1_ctrl;
    logic [DW-1:0] alu_a, alu_b, alu_res;
    logic [8:0]    alu_ctrl;
    logic [5:0]    alu_flags;
    logic          resp_valid, resp_ready, resp_id;
    logic [DW-1:0] resp_res;
    logic [5:0]    resp_flags;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    alu_arb #(.DATA_LEN(DW), .CNT_LEN(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_res    (alu_res),
        .alu_flags  (alu_flags),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_res   (resp_res),
        .resp_flags (resp_flags),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ctrl = {OP,LR,AL,or,xor,and,cmp,sign,shift}.
    // Returns {flags[5:0], result}; flags = {eq,ge,lt,neq,ltu,geu}.
    function automatic logic [DW+5:0] alu_f(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [8:0]    c);
        logic [DW-1:0] r;
        logic [5:0]    f;
        int            sh;
        sh = int'(b[4:0]);
        if (c[0])      r = c[7] ? (a << sh) : (c[6] ? DW'($signed(a) >>> sh) : (a >> sh));
        else if (c[2]) r = c[1] ? DW'($signed(a) < $signed(b)) : DW'(a < b);
        else if (c[3]) r = a & b;
        else if (c[4]) r = a ^ b;
        else if (c[5]) r = a | b;
        else           r = c[8] ? (a - b) : (a + b);
        f = {a == b, $signed(a) >= $signed(b), $signed(a) < $signed(b), a != b, a < b, a >= b};
        return {f, r};
    endfunction

    always_comb {alu_flags, alu_res} = alu_f(alu_a, alu_b, alu_ctrl);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_full;
    int            m_last;
    bit            m_id;
    logic [DW-1:0] m_res;
    logic [5:0]    m_flags;
    int            m_cnt[2];
    logic          obs_r0, obs_r1;   // DUT readies seen in the last step

    task automatic model_reset();
        m_full  = 0;
        m_last  = 1;
        m_id    = 0;
        m_res   = '0;
        m_flags = '0;
        m_cnt   = '{0, 0};
    endtask

    // One clock cycle: the inputs are already applied. Compare at the falling
    // edge, advance the model, then return 1 time unit after the rising edge.
    task automatic step();
        bit            can;
        int            g;
        logic [DW-1:0] ea, eb;
        logic [8:0]    ec;
        logic [DW+5:0] r;
        @(negedge clk);
        check("resp_valid", resp_valid, m_full);
        check("resp_id",    resp_id,    m_id);
        check("resp_res",   resp_res,   m_res);
        check("resp_flags", resp_flags, m_flags);
        check("grant_cnt0", grant_cnt0, m_cnt[0]);
        check("grant_cnt1", grant_cnt1, m_cnt[1]);

        can = !m_full || resp_ready;
        g   = -1;
        if (can) begin
            if (req0_valid && req1_valid) g = 1 - m_last;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        ea = '0; eb = '0; ec = '0;
        if (g == 0) begin ea = req0_a; eb = req0_b; ec = req0_ctrl; end
        if (g == 1) begin ea = req1_a; eb = req1_b; ec = req1_ctrl; end
        check("req0_ready", req0_ready, g == 0);
        check("req1_ready", req1_ready, g == 1);
        check("alu_a",      alu_a,      ea);
        check("alu_b",      alu_b,      eb);
        check("alu_ctrl",   alu_ctrl,   ec);
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;

        if (g >= 0) begin
            r       = alu_f(ea, eb, ec);
            m_res   = r[DW-1:0];
            m_flags = r[DW+5:DW];
            m_id    = g[0];
            m_last  = g;
            m_full  = 1;
            if (m_cnt[g] < SAT) m_cnt[g]++;
        end else if (m_full && resp_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic rr);
        req0_valid = v0;
        req1_valid = v1;
        resp_ready = rr;
    endtask

    // Reset through one full rising edge, with both requesters asserting valid
    // so that any leak of ready during reset is visible.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1, 1, 1);
        model_reset();
        @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_valid",  resp_valid, 0);
        check("rst_res",    resp_res,   0);
        check("rst_alu_a",  alu_a,      0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_a     = '0; req0_b = '0; req0_ctrl = '0;
        req1_a     = '0; req1_b = '0; req1_ctrl = '0;
        drive(0, 0, 0);
        do_reset();

        // Single add from requester 0.
        req0_a = 5; req0_b = 3; req0_ctrl = 9'h000;
        drive(1, 0, 1);
        step();
        check("add_ready0", obs_r0,     1);
        check("add_valid",  resp_valid, 1);
        check("add_res",    resp_res,   8);
        check("add_id",     resp_id,    0);
        check("add_cnt0",   grant_cnt0, 1);

        // A tie right after reset alternates 0,1,0,1, and resp_id follows.
        do_reset();
        req1_a = 32'h10; req1_b = 32'h3; req1_ctrl = 9'h100;
        drive(1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("tie_ready0", obs_r0,  (i % 2) == 0);
            check("tie_ready1", obs_r1,  (i % 2) == 1);
            check("tie_id",     resp_id, i % 2);
        end

        // Backpressure: the slot is full and resp_ready is low.
        drive(0, 0, 0);
        step();
        req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_ctrl = 9'h106;
        drive(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready1", obs_r1, 0);
        end
        drive(0, 1, 1);
        step();
        check("bp_accept", obs_r1,   1);
        check("bp_res",    resp_res, 1);
        check("bp_id",     resp_id,  1);

        // Drain without a refill.
        drive(0, 0, 1);
        step();
        check("drain_valid", resp_valid, 0);
        check("drain_cnt1",  grant_cnt1, 3);

        // Saturation of the grant counter for requester 0.
        do_reset();
        req0_a = 32'h1; req0_b = 32'h2; req0_ctrl = 9'h000;
        drive(1, 0, 1);
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt0", grant_cnt0, SAT);
        drive(0, 0, 1);
        step();

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req0_a    = $urandom; req0_b = $urandom; req0_ctrl = 9'($urandom);
            req1_a    = $urandom; req1_b = $urandom; req1_ctrl = 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                req0_b = req0_a;
                req1_b = req1_a;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            step();
        end

        // Asynchronous reset between edges while the slot is full.
        req0_a = 32'h7; req0_b = 32'h9; req0_ctrl = 9'h000;
        drive(1, 0, 1);
        step();
        drive(1, 1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  resp_valid, 0);
        check("arst_cnt0",   grant_cnt0, 0);
        check("arst_cnt1",   grant_cnt1, 0);
        check("arst_ready0", req0_ready, 0);
        check("arst_ready1", req1_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 1);
        step();
        check("arst_first0", obs_r0, 1);
        step();
        check("arst_second1", obs_r1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, operand/result width.
REQ-002 SHALL have parameter CNT_LEN, default 16, grant-counter width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an ALU operation.
REQ-006 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-007 reqN_a, reqN_b  input  DATA_LEN  operands A/B of requester N.
REQ-008 reqN_ctrl  input  9  {OP,LR,AL,is_or,is_xor,is_and,is_cmp,is_sign,is_shift} of requester N.
REQ-009 alu_a, alu_b  output  DATA_LEN  operands driven to the shared ALU.
REQ-010 alu_ctrl  output  9  control bundle driven to the shared ALU, same bit order.
REQ-011 alu_res  input  DATA_LEN  ALU result, combinational from alu_a/alu_b/alu_ctrl.
REQ-012 alu_flags  input  6  {eq,ge,lt,neq,ltu,geu} from the ALU.
REQ-013 resp_valid  output  1  registered response available.
REQ-014 resp_ready  input  1  consumer takes response.
REQ-015 resp_id  output  1  requester index owning the response.
REQ-016 resp_res  output  DATA_LEN  captured alu_res.
REQ-017 resp_flags  output  6  captured alu_flags.
REQ-018 grant_cnt0, grant_cnt1  output  CNT_LEN  accepted operations per requester.

Function
REQ-019 Output slot SHALL be a 2-state FSM: EMPTY (resp_valid=0), FULL (resp_valid=1).
REQ-020 can_accept SHALL be 1 in EMPTY, or in FULL when resp_ready=1 (same-cycle drain-and-refill).
REQ-021 Only one req SHALL be valid: it is granted if can_accept=1.
REQ-022 Both valid: grant SHALL go to the requester not equal to last_grant (round-robin).
REQ-023 last_grant SHALL update to the granted index only on an accepted transfer.
REQ-024 reqN_ready SHALL be 1 only for the granted requester and only when can_accept=1; never both in one cycle.
REQ-025 alu_a/alu_b/alu_ctrl SHALL be combinational copies of the granted request; with no grant, driven to all-zero.
REQ-026 On acceptance, resp_res, resp_flags, resp_id SHALL load alu_res, alu_flags, granted index at the next edge; resp_valid=1 (latency 1 cycle).
REQ-027 FULL with resp_ready=1 and no acceptance SHALL go to EMPTY; resp_res/flags/id hold their last values.
REQ-028 FULL with resp_ready=0 SHALL hold all resp_* outputs stable and deassert both reqN_ready.
REQ-029 Requester holding valid while not ready SHALL NOT be dropped; ready is not required for valid to be asserted.
REQ-030 grant_cntN SHALL increment by 1 per accepted operation of N, saturating at all-ones (no wrap).
REQ-031 No combinational path SHALL exist from resp_ready to alu_* other than through the grant/can_accept logic.

Reset
REQ-032 rst_n=0 SHALL immediately force: EMPTY, resp_valid=0, resp_res=0, resp_flags=0, resp_id=0, grant_cnt0/1=0, last_grant=1 (req0 wins first tie).
REQ-033 Reset asserted mid-transfer SHALL discard the response in flight; no ready asserted while rst_n=0.
REQ-034 First cycle after rst_n release SHALL accept normally.

Verification
REQ-035 Single add: req0 a=5,b=3,ctrl=0 (add), resp_ready=1 -> req0_ready=1 same cycle; next cycle resp_valid=1,resp_res=8,resp_id=0,grant_cnt0=1.
REQ-036 Tie round-robin: both valid continuously after reset, resp_ready=1 -> grants 0,1,0,1 on four consecutive cycles; resp_id follows 0,1,0,1 one cycle later.
REQ-037 Backpressure: FULL, resp_ready=0 for 3 cycles, req1 valid (a=0xFFFFFFFF,b=1,sub,is_cmp,is_sign) -> req1_ready=0, resp_* stable; on resp_ready=1 req1 accepted same cycle, next resp_res=1 (-1<1 signed).
REQ-038 Drain without refill: FULL, resp_ready=1, no req -> next cycle resp_valid=0, grant_cnt unchanged.
REQ-039 Saturation: CNT_LEN=4, 20 req0 acceptances -> grant_cnt0=15, no wrap.
REQ-040 Async reset: rst_n low between clock edges while FULL -> resp_valid=0 and counters=0 before next edge; after release, tie grants req0 first.
